// File: rtl/bp_me_pkg.sv
// ----------------------------------------------------------------------------
// bp_me_pkg
// Shared definitions for the BedRock memory-side wormhole encoder and decoder.
//   bp_me_wh_encode_state_e  : encoder FSM state encoding
//   wh_cnt_width_gp          : width of flit/beat counters (covers 1024 beats)
//   cdiv()                   : ceiling division for elaboration-time sizing
//   `BP_ME_WH_HEADER_WIDTH   : wormhole header width in bits,
//                              2*cord + 2*cid + len + hdr
// ----------------------------------------------------------------------------
`ifndef BP_ME_PKG_SV
`define BP_ME_PKG_SV

`define BP_ME_WH_HEADER_WIDTH(cord_w, cid_w, len_w, hdr_w) \
    (2*(cord_w) + 2*(cid_w) + (len_w) + (hdr_w))

package bp_me_pkg;

    typedef enum logic [1:0] {
        e_ready = 2'd0,
        e_hdr   = 2'd1,
        e_data  = 2'd2
    } bp_me_wh_encode_state_e;

    localparam int unsigned wh_cnt_width_gp = 16;

    function automatic int unsigned cdiv(input int unsigned a, input int unsigned b);
        return (a + b - 1) / b;
    endfunction

endpackage

`endif

// File: rtl/bp_me_wormhole_len_calc.sv
// ----------------------------------------------------------------------------
// bp_me_wormhole_len_calc
// Combinational packet length calculator for wormhole encoders.
// Maps a BedRock size code and has-data flag to the number of data flits,
// the wormhole len field (flits after the first, truncated) and an overflow
// flag for the untruncated len.
//   size_i      : payload size code, bytes = 1 << size_i
//   has_data_i  : packet carries payload beats
//   beats_o     : data flit count (0 when no data, else at least 1)
//   len_o       : hdr_flits_p + beats_o - 1, truncated to len_width_p
//   overflow_o  : untruncated len does not fit in len_width_p
// Macro BP_ME_WORMHOLE_STREAM_ENCODE_LEN_CHECK_EN builds the overflow compare;
// without it overflow_o is constant 0.
// ----------------------------------------------------------------------------
module bp_me_wormhole_len_calc
    import bp_me_pkg::*;
#(
    parameter int unsigned flit_width_p = 64,
    parameter int unsigned len_width_p  = 5,
    parameter int unsigned hdr_flits_p  = 2
)
(
    input  logic [2:0]                 size_i,
    input  logic                       has_data_i,
    output logic [wh_cnt_width_gp-1:0] beats_o,
    output logic [len_width_p-1:0]     len_o,
    output logic                       overflow_o
);

    logic [31:0]                w_bits;
    logic [wh_cnt_width_gp-1:0] w_beats;

    always_comb begin
        w_bits  = 32'd8 << size_i;
        w_beats = '0;
        if (has_data_i) begin
            w_beats = wh_cnt_width_gp'((w_bits + 32'(flit_width_p) - 32'd1) / 32'(flit_width_p));
            // a payload always occupies at least one beat
            if (w_beats == '0) begin
                w_beats = wh_cnt_width_gp'(1);
            end
        end
    end

    assign beats_o = w_beats;
    assign len_o   = len_width_p'(32'(hdr_flits_p) + 32'(w_beats) - 32'd1);

`ifdef BP_ME_WORMHOLE_STREAM_ENCODE_LEN_CHECK_EN
    logic [31:0] w_len_full;
    assign w_len_full = 32'(hdr_flits_p) + 32'(w_beats) - 32'd1;
    assign overflow_o = (w_len_full > ((32'd1 << len_width_p) - 32'd1));
`else
    assign overflow_o = 1'b0;
`endif

endmodule

// File: rtl/bp_me_wormhole_stream_encode.sv
// ----------------------------------------------------------------------------
// bp_me_wormhole_stream_encode
// Sequential wormhole packet encoder. Accepts a BedRock header plus an
// optional stream of data beats, prepends the wormhole routing header and
// serialises the packet onto one ready/valid flit link.
//
// Wormhole header, dst_cord at the LSBs, zero-padded to whole flits:
//   {header, dst_cid, src_cid, src_cord, len, dst_cord}
//
// Ports
//   clk_i, reset_n_i          : clock, async active-low reset
//   header_i .. dst_cid_i     : message header and routing fields
//   header_v_i / header_ready_and_o : header handshake
//   data_i, data_v_i / data_ready_and_o : payload beats (pass-through)
//   link_data_o, link_v_o / link_ready_and_i : output flit link
//   len_err_o                 : sticky len overflow flag
//
// Optional feature: BP_ME_WORMHOLE_STREAM_ENCODE_LEN_CHECK_EN enables the
// sticky len overflow flag; otherwise len_err_o is constant 0.
//
// state   | meaning
// --------+---------------------------------------------------------------
// e_ready | idle, header accepted; link idle
// e_hdr   | sending latched header flits, LSB flit first
// e_data  | data beats pass straight from source to link
// ----------------------------------------------------------------------------
module bp_me_wormhole_stream_encode
    import bp_me_pkg::*;
#(
    parameter int unsigned flit_width_p = 64,
    parameter int unsigned cord_width_p = 7,
    parameter int unsigned cid_width_p  = 2,
    parameter int unsigned len_width_p  = 5,
    parameter int unsigned hdr_width_p  = 104
)
(
    input  logic                    clk_i,
    input  logic                    reset_n_i,

    input  logic [hdr_width_p-1:0]  header_i,
    input  logic [2:0]              size_i,
    input  logic                    has_data_i,
    input  logic [cord_width_p-1:0] src_cord_i,
    input  logic [cord_width_p-1:0] dst_cord_i,
    input  logic [cid_width_p-1:0]  src_cid_i,
    input  logic [cid_width_p-1:0]  dst_cid_i,
    input  logic                    header_v_i,
    output logic                    header_ready_and_o,

    input  logic [flit_width_p-1:0] data_i,
    input  logic                    data_v_i,
    output logic                    data_ready_and_o,

    output logic [flit_width_p-1:0] link_data_o,
    output logic                    link_v_o,
    input  logic                    link_ready_and_i,

    output logic                    len_err_o
);

    localparam int unsigned wh_width_lp =
        `BP_ME_WH_HEADER_WIDTH(cord_width_p, cid_width_p, len_width_p, hdr_width_p);
    localparam int unsigned hdr_flits_lp     = cdiv(wh_width_lp, flit_width_p);
    localparam int unsigned pad_width_lp     = hdr_flits_lp * flit_width_p;
    localparam int unsigned hdr_idx_width_lp = (hdr_flits_lp > 1) ? $clog2(hdr_flits_lp) : 1;

    localparam logic [wh_cnt_width_gp-1:0] cnt_one_lp      = wh_cnt_width_gp'(1);
    localparam logic [wh_cnt_width_gp-1:0] hdr_last_cnt_lp = wh_cnt_width_gp'(hdr_flits_lp - 1);

    logic [wh_cnt_width_gp-1:0]                w_beats;
    logic [len_width_p-1:0]                    w_len;
    logic                                      w_len_ovf;
    logic [wh_width_lp-1:0]                    w_wh_hdr;
    logic [hdr_flits_lp-1:0][flit_width_p-1:0] w_hdr_padded;
    logic [hdr_idx_width_lp-1:0]               w_hdr_idx;
    logic                                      w_hdr_last;
    logic                                      w_data_last;

    bp_me_wh_encode_state_e                    r_state;
    logic [wh_cnt_width_gp-1:0]                r_cnt;
    logic [wh_cnt_width_gp-1:0]                r_beats;
    logic                                      r_has_data;
    logic [hdr_flits_lp-1:0][flit_width_p-1:0] r_hdr;

    bp_me_wormhole_len_calc #(
        .flit_width_p (flit_width_p),
        .len_width_p  (len_width_p),
        .hdr_flits_p  (hdr_flits_lp)
    ) u_len_calc (
        .size_i     (size_i),
        .has_data_i (has_data_i),
        .beats_o    (w_beats),
        .len_o      (w_len),
        .overflow_o (w_len_ovf)
    );

    assign w_wh_hdr     = {header_i, dst_cid_i, src_cid_i, src_cord_i, w_len, dst_cord_i};
    assign w_hdr_padded = pad_width_lp'(w_wh_hdr);

    assign w_hdr_idx   = r_cnt[hdr_idx_width_lp-1:0];
    assign w_hdr_last  = (r_cnt == hdr_last_cnt_lp);
    assign w_data_last = (r_cnt == (r_beats - cnt_one_lp));

    // Outputs decode only from registered state, so an async reset
    // drops link_v_o and data_ready_and_o immediately.
    always_comb begin
        header_ready_and_o = 1'b0;
        data_ready_and_o   = 1'b0;
        link_v_o           = 1'b0;
        link_data_o        = '0;
        unique case (r_state)
            e_ready: begin
                header_ready_and_o = 1'b1;
            end
            e_hdr: begin
                link_v_o    = 1'b1;
                link_data_o = r_hdr[w_hdr_idx];
            end
            e_data: begin
                link_v_o         = data_v_i;
                data_ready_and_o = link_ready_and_i;
                link_data_o      = data_i;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state    <= e_ready;
            r_cnt      <= '0;
            r_beats    <= '0;
            r_has_data <= 1'b0;
            r_hdr      <= '0;
        end else begin
            unique case (r_state)
                e_ready: begin
                    if (header_v_i) begin
                        r_hdr      <= w_hdr_padded;
                        r_beats    <= w_beats;
                        r_has_data <= has_data_i;
                        r_cnt      <= '0;
                        r_state    <= e_hdr;
                    end
                end
                e_hdr: begin
                    if (link_ready_and_i) begin
                        if (w_hdr_last) begin
                            r_cnt   <= '0;
                            r_state <= r_has_data ? e_data : e_ready;
                        end else begin
                            r_cnt <= r_cnt + cnt_one_lp;
                        end
                    end
                end
                e_data: begin
                    if (data_v_i && link_ready_and_i) begin
                        if (w_data_last) begin
                            r_cnt   <= '0;
                            r_state <= e_ready;
                        end else begin
                            r_cnt <= r_cnt + cnt_one_lp;
                        end
                    end
                end
                default: begin
                    r_state <= e_ready;
                end
            endcase
        end
    end

`ifdef BP_ME_WORMHOLE_STREAM_ENCODE_LEN_CHECK_EN
    logic r_len_err;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_len_err <= 1'b0;
        end else if ((r_state == e_ready) && header_v_i && w_len_ovf) begin
            r_len_err <= 1'b1;
        end
    end

    assign len_err_o = r_len_err;
`else
    // overflow is constant 0 when the check is not built
    assign len_err_o = w_len_ovf;
`endif

endmodule

// File: doc/bp_me_wormhole_stream_encode.md
# bp_me_wormhole_stream_encode

Sequential wormhole packet encoder for BedRock memory-side traffic. It accepts one message header and an optional stream of data beats, prepends the wormhole routing header, and serialises the packet into flits onto a single ready/valid link. It sits between a BedRock stream source (CCE, I/O master) and the wormhole router/adapter. It generalises the combinational header encoder to any header width and any message type, with length computed from a size field and a has-data flag.

## Interface
- flit_width_p, "inv": link flit width in bits; also the data beat width.
- cord_width_p, "inv": coordinate width.
- cid_width_p, "inv": concentrator id width.
- len_width_p, "inv": wormhole length field width.
- hdr_width_p, "inv": BedRock message header width.
- clk_i  input  1  clock.
- reset_n_i  input  1  reset, asynchronous, active-low.
- header_i  input  hdr_width_p  message header.
- size_i  input  3  payload size code; bytes = 1<<size_i (1..128).
- has_data_i  input  1  packet carries payload beats.
- src_cord_i, dst_cord_i  input  cord_width_p  source and destination coordinates.
- src_cid_i, dst_cid_i  input  cid_width_p  source and destination concentrator ids.
- header_v_i  input  1; header_ready_and_o  output  1.
- data_i  input  flit_width_p  payload beat.
- data_v_i  input  1; data_ready_and_o  output  1.
- link_data_o  output  flit_width_p; link_v_o  output  1; link_ready_and_i  input  1.
- len_err_o  output  1  sticky length-overflow flag.

## Operation
- Wormhole header W = {header_i, dst_cid, src_cid, src_cord, len, dst_cord}, with dst_cord at the LSBs. Width Wb = 2*cord + 2*cid + len + hdr bits. The header is zero-padded to H = CDIV(Wb, flit_width_p) flits.
- Data flits: D = max(1, CDIV(8<<size_i, flit_width_p)) if has_data_i, else 0. len = H + D - 1, computed at full width, then truncated to len_width_p.
- The FSM has three states.
  - e_ready: header_ready_and_o=1. On header handshake, latch the padded header, D, and the has_data flag; clear the counter; go to e_hdr.
  - e_hdr: link_v_o=1; link_data_o = flit[cnt] of the latched header, LSB flit first. Each link handshake increments cnt. On the handshake of flit H-1, go to e_data if D>0, else go to e_ready.
  - e_data: combinational pass-through. link_v_o=data_v_i, data_ready_and_o=link_ready_and_i, link_data_o=data_i. Count handshakes. On the handshake of beat D-1, go to e_ready.
- data_ready_and_o=0 outside e_data. Extra source beats are never consumed by this packet.
- header_ready_and_o=0 outside e_ready.

## Timing
- Reset: state=e_ready, counter=0, header register=0, len_err_o=0. Asynchronous assertion forces link_v_o=0 and data_ready_and_o=0 immediately. Any partial packet is abandoned, with no recovery flits.
- Header handshake in cycle N gives the first header flit valid in cycle N+1.
- Minimum packet occupancy is 1 + H + D cycles. This includes one bubble between packets, because the header is not accepted during the last flit.
- link_v_o stays asserted while stalled. link_data_o is stable until handshake in e_hdr.
- Data path adds zero latency and no buffering.

## Configuration
- BP_ME_WORMHOLE_STREAM_ENCODE_LEN_CHECK_EN defined:
  - If the untruncated len > 2^len_width_p - 1 at header acceptance, len_err_o sets the next cycle. It stays set until reset.
  - The packet is still sent with the truncated len.
- Undefined: len_err_o is tied to 0 and no compare logic is built.

## Structure
- bp_me_pkg: the state enum bp_me_wh_encode_state_e {e_ready, e_hdr, e_data} and the wormhole header width macro, reused by the decoder.
- Sub-module bp_me_wormhole_len_calc is combinational. It maps (size_i, has_data_i) to D, len, and overflow, and is shared with future encoders.

## Test plan
Common parameters: flit 64, cord 7, cid 2, len 5, hdr 104, giving Wb=127 and H=2.

- Header-only, has_data=0: len=1. Exactly 2 flits, carrying header bits [63:0] then [127:64], with bit 127 = 0. Then header_ready_and_o=1 one cycle later.
- size=64B write: len=9, 2 header flits then 8 data flits equal to the beats in order. data_ready_and_o is high only in e_data.
- size=1B write: D=1, len=2, 3 flits total.
- Random link_ready_and_i (50%) and data_v_i gaps on a 64B packet: no flit lost, duplicated, or reordered; link_data_o is held while stalled.
- With the macro and len_width_p=3, a 128B write (len=17): len_err_o=1 from the cycle after acceptance and held; flits carry len=1. Without the macro, len_err_o stays 0.
- reset_n_i asserted during data flit 3: link_v_o drops the same cycle. After release, a fresh header-only packet encodes correctly.
